// File: rtl/mux_reassembler.sv
`default_nettype none
// ============================================================================
// Module   : mux_reassembler
// Purpose  : Rebuilds 32-bit words from the byte-serial output of a 4-channel
//            mux (MSB first, one byte per valid cycle, lane = channel),
//            tags them with their channel and buffers them in a show-ahead
//            FIFO behind a valid/ready interface. Sticky flags report channel
//            switches mid-word and words dropped on FIFO overflow.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_chan     byte strobe and channel of the current byte
//   in_data0..in_data3    byte lanes; only lane in_chan is sampled
//   out_ready             downstream accepts the head word
//   err_clr               clears both sticky error flags
//   out_valid/out_chan/out_word  head FIFO entry
//   fifo_full             FIFO holds FIFO_DEPTH words (advisory only)
//   err_chan, err_ovf     sticky protocol / overflow flags
//   word_cnt              per-channel pushed-word counters, CNT_W each
// Configuration
//   MUX_REASM_STATS_EN    when defined, builds the saturating word counters;
//                         otherwise word_cnt is tied to zero.
// ============================================================================
module mux_reassembler #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         in_chan,
  input  logic [7:0]         in_data0,
  input  logic [7:0]         in_data1,
  input  logic [7:0]         in_data2,
  input  logic [7:0]         in_data3,
  input  logic               out_ready,
  input  logic               err_clr,
  output logic               out_valid,
  output logic [1:0]         out_chan,
  output logic [31:0]        out_word,
  output logic               fifo_full,
  output logic               err_chan,
  output logic               err_ovf,
  output logic [4*CNT_W-1:0] word_cnt
);

  localparam int              c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_chan, w_chan_nxt;
  // Only the first three bytes need storage; the fourth goes straight into
  // the FIFO entry.
  logic [23:0] r_asm, w_asm_nxt;
  logic [7:0]  w_byte;
  logic        w_push;
  logic [33:0] w_push_entry;
  logic        w_chan_err;

  // ---------------------------------------------------------------- lane select
  always_comb begin
    w_byte = in_data0;
    case (in_chan)
      2'd0:    w_byte = in_data0;
      2'd1:    w_byte = in_data1;
      2'd2:    w_byte = in_data2;
      default: w_byte = in_data3;
    endcase
  end

  // ---------------------------------------------------------------- assembly FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_chan  <= 2'd0;
      r_asm   <= 24'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_chan  <= w_chan_nxt;
      r_asm   <= w_asm_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_chan_nxt   = r_chan;
    w_asm_nxt    = r_asm;
    w_push       = 1'b0;
    w_chan_err   = 1'b0;
    w_push_entry = {r_chan, r_asm, w_byte};
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_asm_nxt[23:16] = w_byte;
          w_chan_nxt       = in_chan;
          w_idx_nxt        = 2'd1;
          w_state_nxt      = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          if (in_chan != r_chan) begin
            // Drop the partial word and restart on the new channel.
            w_chan_err       = 1'b1;
            w_asm_nxt[23:16] = w_byte;
            w_chan_nxt       = in_chan;
            w_idx_nxt        = 2'd1;
          end else begin
            case (r_idx)
              2'd1: begin
                w_asm_nxt[15:8] = w_byte;
                w_idx_nxt       = 2'd2;
              end
              2'd2: begin
                w_asm_nxt[7:0] = w_byte;
                w_idx_nxt      = 2'd3;
              end
              default: begin
                w_push      = 1'b1;
                w_idx_nxt   = 2'd0;
                w_state_nxt = ST_IDLE;
              end
            endcase
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [33:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr, r_rptr;
  logic [c_AW:0]   r_count;
  logic            w_pop, w_full, w_wr, w_ovf;

  assign w_full = (r_count == c_DEPTH);
  assign w_pop  = out_valid & out_ready;
  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_ovf  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 34'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_push_entry;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_wr) r_count <= r_count - 1'b1;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_chan  = r_mem[r_rptr][33:32];
  assign out_word  = r_mem[r_rptr][31:0];
  assign fifo_full = w_full;

  // ---------------------------------------------------------------- sticky errors
  logic r_err_chan, r_err_ovf;

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_chan <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_err_chan <= w_chan_err | (r_err_chan & ~err_clr);
      r_err_ovf  <= w_ovf      | (r_err_ovf  & ~err_clr);
    end
  end

  assign err_chan = r_err_chan;
  assign err_ovf  = r_err_ovf;

  // ---------------------------------------------------------------- statistics
`ifdef MUX_REASM_STATS_EN
  generate
    for (genvar c = 0; c < 4; c++) begin : g_stats
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_wr && (w_push_entry[33:32] == 2'(c)) && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign word_cnt[CNT_W*c +: CNT_W] = r_cnt;
    end
  endgenerate
`else
  assign word_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_reassembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_reassembler
// Purpose  : Self-checking bench for mux_reassembler. A queue-based reference
//            model follows the byte stream; a negedge compare process checks
//            every output each cycle, and directed scenarios add literal
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_reassembler;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [1:0]         in_chan;
  logic [7:0]         in_data0, in_data1, in_data2, in_data3;
  logic               out_ready;
  logic               err_clr;
  logic               out_valid;
  logic [1:0]         out_chan;
  logic [31:0]        out_word;
  logic               fifo_full;
  logic               err_chan;
  logic               err_ovf;
  logic [4*CNT_W-1:0] word_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  mux_reassembler #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .out_ready(out_ready), .err_clr(err_clr), .out_valid(out_valid),
    .out_chan(out_chan), .out_word(out_word), .fifo_full(fifo_full),
    .err_chan(err_chan), .err_ovf(err_ovf), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [33:0]      m_q[$];
  logic [7:0]       m_bytes[$];
  logic [1:0]       m_chan = 2'd0;
  logic             m_errc = 1'b0;
  logic             m_erro = 1'b0;
  logic [CNT_W-1:0] m_cnt [4] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_bytes.delete();
      m_errc = 1'b0;
      m_erro = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else begin
      logic        do_pop, was_full, have_word, newc, newo;
      logic [7:0]  lanes [4];
      logic [31:0] w;
      do_pop    = (m_q.size() > 0) && out_ready;
      was_full  = (m_q.size() == FIFO_DEPTH);
      have_word = 1'b0;
      newc      = 1'b0;
      newo      = 1'b0;
      w         = 32'd0;
      lanes[0] = in_data0; lanes[1] = in_data1; lanes[2] = in_data2; lanes[3] = in_data3;
      if (in_valid) begin
        if (m_bytes.size() > 0 && in_chan != m_chan) begin
          newc = 1'b1;
          m_bytes.delete();
        end
        m_bytes.push_back(lanes[in_chan]);
        m_chan = in_chan;
        if (m_bytes.size() == 4) begin
          have_word = 1'b1;
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (have_word) begin
        if (!was_full || do_pop) begin
          m_q.push_back({m_chan, w});
          if (m_cnt[m_chan] != '1) m_cnt[m_chan] = m_cnt[m_chan] + 1'b1;
        end else begin
          newo = 1'b1;
        end
      end
      m_errc = newc | (m_errc & ~err_clr);
      m_erro = newo | (m_erro & ~err_clr);
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    logic [4*CNT_W-1:0] exp_cnt;
    exp_cnt = '0;
`ifdef MUX_REASM_STATS_EN
    for (int i = 0; i < 4; i++) exp_cnt[CNT_W*i +: CNT_W] = m_cnt[i];
`endif
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("out_chan", 64'(out_chan), 64'(m_q[0][33:32]));
      chk("out_word", 64'(out_word), 64'(m_q[0][31:0]));
    end
    chk("fifo_full", 64'(fifo_full), 64'(m_q.size() == FIFO_DEPTH));
    chk("err_chan", 64'(err_chan), 64'(m_errc));
    chk("err_ovf", 64'(err_ovf), 64'(m_erro));
    chk("word_cnt", 64'(word_cnt), 64'(exp_cnt));
  end

  // ---------------------------------------------------------------- stimulus
  // Drive one byte right after a negedge, return at the next negedge with
  // in_valid already low; a following call raises it again with no gap.
  task automatic send_byte(input logic [1:0] ch, input logic [7:0] d);
    in_valid = 1'b1;
    in_chan  = ch;
    in_data0 = ~d; in_data1 = ~d; in_data2 = ~d; in_data3 = ~d;
    case (ch)
      2'd0:    in_data0 = d;
      2'd1:    in_data1 = d;
      2'd2:    in_data2 = d;
      default: in_data3 = d;
    endcase
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(ch, w[31-8*k -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_chan = 2'd0;
    in_data0 = 8'd0; in_data1 = 8'd0; in_data2 = 8'd0; in_data3 = 8'd0;
    out_ready = 1'b1; err_clr = 1'b0;
    idle(2);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_word", 64'(out_word), 64'd0);
    chk("rst out_chan", 64'(out_chan), 64'd0);
    chk("rst word_cnt", 64'(word_cnt), 64'd0);
    rst = 1'b0;
    idle(1);

    // single word
    send_word(2'd2, 32'hAABBCCDD);
    chk("single valid", 64'(out_valid), 64'd1);
    chk("single word", 64'(out_word), 64'hAABBCCDD);
    chk("single chan", 64'(out_chan), 64'd2);
    idle(1);
    chk("single gone", 64'(out_valid), 64'd0);

    // gapped bytes
    send_byte(2'd1, 8'h11); idle(3);
    send_byte(2'd1, 8'h22); idle(3);
    send_byte(2'd1, 8'h33); idle(3);
    send_byte(2'd1, 8'h44);
    chk("gap word", 64'(out_word), 64'h11223344);
    chk("gap chan", 64'(out_chan), 64'd1);
    chk("gap err_chan", 64'(err_chan), 64'd0);
    idle(2);

    // overflow
    out_ready = 1'b0;
    send_word(2'd0, 32'h01020304);
    send_word(2'd3, 32'h05060708);
    chk("ovf full", 64'(fifo_full), 64'd1);
    send_word(2'd1, 32'h090A0B0C);
    chk("ovf flag", 64'(err_ovf), 64'd1);
    out_ready = 1'b1;
    chk("ovf head0 word", 64'(out_word), 64'h01020304);
    chk("ovf head0 chan", 64'(out_chan), 64'd0);
    idle(1);
    chk("ovf head1 word", 64'(out_word), 64'h05060708);
    chk("ovf head1 chan", 64'(out_chan), 64'd3);
    idle(1);
    chk("ovf drained", 64'(out_valid), 64'd0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("ovf cleared", 64'(err_ovf), 64'd0);

    // channel switch mid-word
    send_byte(2'd1, 8'h77);
    send_byte(2'd1, 8'h66);
    send_word(2'd0, 32'hEEDDCCBB);
    chk("sw err_chan", 64'(err_chan), 64'd1);
    chk("sw word", 64'(out_word), 64'hEEDDCCBB);
    chk("sw chan", 64'(out_chan), 64'd0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("sw cleared", 64'(err_chan), 64'd0);
    idle(1);
    chk("sw single", 64'(out_valid), 64'd0);

    // asynchronous reset mid-word with a word buffered
    out_ready = 1'b0;
    send_word(2'd1, 32'h12345678);
    send_byte(2'd3, 8'h99);
    send_byte(2'd3, 8'h88);
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1 chk("async rst valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(2'd3, 32'hCAFEF00D);
    chk("post-rst word", 64'(out_word), 64'hCAFEF00D);
    chk("post-rst chan", 64'(out_chan), 64'd3);
    chk("post-rst valid", 64'(out_valid), 64'd1);
    idle(2);

    // statistics
    rst = 1'b1; idle(1); rst = 1'b0;
    send_word(2'd1, 32'h10000001);
    send_word(2'd1, 32'h10000002);
    send_word(2'd1, 32'h10000003);
    send_word(2'd2, 32'h20000001);
    idle(2);
`ifdef MUX_REASM_STATS_EN
    chk("stats cnt", 64'(word_cnt), 64'h0000_0001_0003_0000);
`else
    chk("stats cnt", 64'(word_cnt), 64'd0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_reassembler.md
# mux_reassembler

Byte-stream reassembler that sits directly downstream of the 4-channel mux. It consumes the mux's serialized output: one byte per valid cycle, most significant byte first, on the lane selected by the channel. It rebuilds each 32-bit word with its channel tag and buffers completed words in a small FIFO. Words are presented on a valid/ready interface to the next stage, with sticky error flags for protocol violations and buffer overflow.

## Interface
Parameters:
- FIFO_DEPTH, 2, number of completed-word entries buffered (≥2, power of 2).
- CNT_W, 16, width of each per-channel word counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  mux valid; one byte transferred per cycle while high.
- in_chan  in  2  channel of the current byte; selects the lane.
- in_data0..in_data3  in  8 each  byte lanes; only lane in_chan is sampled.
- out_ready  in  1  downstream accepts the head word when high.
- err_clr  in  1  clears sticky error flags.
- out_valid  out  1  head FIFO word is valid.
- out_chan  out  2  channel of the head word.
- out_word  out  32  reassembled word.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- err_chan  out  1  sticky flag: channel changed mid-word.
- err_ovf  out  1  sticky flag: completed word dropped because the FIFO was full.
- word_cnt  out  4*CNT_W  per-channel accepted-word counters; channel c is at [CNT_W*c +: CNT_W].

## Operation
- Assembly FSM states:
  - IDLE: byte index 0.
  - COLLECT: byte index 1..3, with the channel latched.
- Byte placement: byte index k is written to assembly bits [31-8k -: 8]. The first byte goes to [31:24] and the fourth to [7:0].
- IDLE with in_valid high: capture the byte, latch in_chan, set index to 1, go to COLLECT.
- COLLECT with in_valid low: hold all state. Gaps of any length are legal.
- COLLECT with in_valid high and in_chan equal to the latched channel: capture the byte and increment the index.
  - On the 4th byte (index 3), the word is complete: push {chan, word} to the FIFO and return to IDLE.
- COLLECT with in_valid high and in_chan different from the latched channel:
  - Set err_chan and discard the partial word.
  - Treat the current byte as byte 0 of a new word on the new channel (index becomes 1).
- FIFO is show-ahead: out_valid = not empty; out_chan and out_word show the head entry. A pop occurs when out_valid && out_ready.
- Push while full:
  - With a pop in the same cycle: legal, and the word is stored.
  - Without a pop: the word is dropped, err_ovf is set, and the FIFO is unchanged.
- Push and pop in the same cycle on a non-empty FIFO: occupancy is unchanged and order is preserved.
- fifo_full = (occupancy == FIFO_DEPTH). It is combinational from registered occupancy.
- err_clr clears both sticky flags. If a new error occurs in the same cycle as err_clr, setting wins.

## Timing
- Reset values (asserted asynchronously, immediately on rst):
  - out_valid=0, out_chan=0, out_word=0, fifo_full=0, err_chan=0, err_ovf=0, word_cnt=0.
  - FSM in IDLE, FIFO empty.
- Reset mid-word discards the partial word and all buffered words. The first in_valid cycle after rst deasserts is byte 0.
- Latency: the 4th byte is sampled at edge N; out_valid is high after edge N if the FIFO was empty. This is 1 cycle from the last byte to availability.
- Throughput: 1 word per 4 valid cycles. Back-to-back words with no in_valid gap are supported.
- out_word and out_chan are stable while out_valid && !out_ready.
- No backpressure to the mux. fifo_full is advisory only; overflow is reported, not prevented.

## Configuration
- MUX_REASM_STATS_EN defined:
  - Four CNT_W-bit counters. Counter c increments when a word on channel c is pushed into the FIFO.
  - Dropped (overflow) words and discarded partial words are not counted.
  - Counters saturate at all-ones and are cleared only by rst.
- Not defined: no counter logic is built, and word_cnt is tied to 0.

## Test plan
- Single word: in_chan=2, in_data2 = AA, BB, CC, DD on 4 consecutive valid cycles, out_ready=1.
  - Required: out_valid high for 1 cycle, starting 1 cycle after DD, with out_chan=2 and out_word=0xAABBCCDD.
- Gapped bytes: chan 1 bytes 11, 22, 33, 44, with in_valid low for 3 cycles between each.
  - Required: out_word=0x11223344, out_chan=1, err_chan=0.
- Overflow: out_ready=0; send 3 complete words (chan0 0x01020304, chan3 0x05060708, chan1 0x090A0B0C).
  - Required: fifo_full=1 after the second word; err_ovf=1 after the third.
  - Then raise out_ready: exactly 0x01020304/chan0, then 0x05060708/chan3, then out_valid=0.
- Channel switch: 2 bytes on chan1, then 4 bytes EE, DD, CC, BB on chan0.
  - Required: err_chan=1; a single output word 0xEEDDCCBB/chan0.
  - Pulse err_clr: err_chan returns to 0 the next cycle.
- Async reset: assert rst between edges after 2 bytes of a word with 1 word buffered.
  - Required: out_valid=0 before the next edge.
  - Then a fresh 4-byte word 0xCAFEF00D/chan3 is output correctly.
- Stats: with MUX_REASM_STATS_EN, 3 words on chan1 and 1 on chan2.
  - Required: word_cnt[31:16]=3, word_cnt[47:32]=1, others 0.
  - Without the macro: word_cnt=0.
